is_equal_seq32: RTL and testbench

- Multi-cycle signed comparator for the ALU datapath; the sequential counterpart of the combinational 32-bit inequality gate.
- Compares data_operandA against data_operandB one DIGIT-bit chunk per cycle, from the MSB chunk down.
- Reports isEqual, isNotEqual and signed isLessThan through a start/busy/done handshake.
- Used by the branch/compare path where a single-cycle 32-bit compare tree does not meet timing.

---
 rtl/is_equal_seq32.sv | 160 ++++++++++++++++
 tb/tb_is_equal_seq32.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/is_equal_seq32.sv
// Multi-cycle signed comparator: equality, inequality and signed less-than, one DIGIT-bit chunk per cycle from the MSB chunk down.
// Latency: done pulses NCHUNK+1 cycles after start; with COMPARE_EARLY_EXIT_EN, (NCHUNK-1-j)+2 cycles when chunk j is the first difference.
// Backpressure: none; start is sampled only when idle and not pulsing done, and is otherwise dropped (no queuing).
// Optional feature macro: COMPARE_EARLY_EXIT_EN (stop scanning at the first differing chunk).
module is_equal_seq32 #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic             busy,
   output logic             done,
   output logic             isEqual,
   output logic             isNotEqual,
   output logic             isLessThan
);

   localparam int NCHUNK = WIDTH / DIGIT;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             diff_q, diff_d;
   logic             lt_q, lt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             eq_q, eq_d;
   logic             ne_q, ne_d;
   logic             ltr_q, ltr_d;

   logic [DIGIT-1:0] chunk_a;
   logic [DIGIT-1:0] chunk_b;
   logic             chunk_ne;
   logic             first_lt;
   logic             scan_exit;

   assign chunk_a  = opa_q[int'(idx_q)*DIGIT +: DIGIT];
   assign chunk_b  = opb_q[int'(idx_q)*DIGIT +: DIGIT];
   assign chunk_ne = (chunk_a != chunk_b);

   // In the top chunk differing sign bits settle the signed order directly;
   // everywhere else the remaining bits are ordered as plain unsigned values.
   assign first_lt = ((idx_q == TOP_IDX) && (opa_q[WIDTH-1] != opb_q[WIDTH-1]))
                     ? opa_q[WIDTH-1]
                     : (chunk_a < chunk_b);

   // Leave the scan after chunk 0, or at the first difference when early exit is built in.
`ifdef COMPARE_EARLY_EXIT_EN
   assign scan_exit = (idx_q == '0) || (chunk_ne && !diff_q);
`else
   assign scan_exit = (idx_q == '0);
`endif

   // Next-state and datapath updates; every register holds unless a state overrides it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      diff_d  = diff_q;
      lt_d    = lt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      ne_d    = ne_q;
      ltr_d   = ltr_q;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            // The done cycle still counts as finishing, so a start there is dropped.
            if (start && !done_q) begin
               opa_d   = data_operandA;
               opb_d   = data_operandB;
               idx_d   = TOP_IDX;
               diff_d  = 1'b0;
               lt_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_BUSY;
            end
         end

         S_BUSY: begin
            busy_d = 1'b1;
            // Only the first differing chunk decides the order; later chunks are ignored.
            if (chunk_ne && !diff_q) begin
               diff_d = 1'b1;
               lt_d   = first_lt;
            end
            if (scan_exit) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            eq_d    = ~diff_q;
            ne_d    = diff_q;
            ltr_d   = lt_q & diff_q;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any scan in flight without a done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         diff_q  <= 1'b0;
         lt_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         ne_q    <= 1'b0;
         ltr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         diff_q  <= diff_d;
         lt_q    <= lt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         ne_q    <= ne_d;
         ltr_q   <= ltr_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign isEqual    = eq_q;
   assign isNotEqual = ne_q;
   assign isLessThan = ltr_q;

endmodule

// File: tb/tb_is_equal_seq32.sv
// Directed bench for is_equal_seq32: reset, equality, signed ordering, ignored start, abort and back-to-back.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge as well.
// Latency expectations depend on whether COMPARE_EARLY_EXIT_EN is defined for the build.
module tb_is_equal_seq32;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        busy;
   logic        done;
   logic        isEqual;
   logic        isNotEqual;
   logic        isLessThan;

   int n_pass  = 0;
   int n_total = 0;

   localparam int BUDGET = 20;

`ifdef COMPARE_EARLY_EXIT_EN
   localparam int LAT_TOP = 2;
`else
   localparam int LAT_TOP = 9;
`endif
   localparam int LAT_FULL = 9;

   is_equal_seq32 dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .busy          (busy),
      .done          (done),
      .isEqual       (isEqual),
      .isNotEqual    (isNotEqual),
      .isLessThan    (isLessThan)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Called at a falling edge: pulse start for one cycle, then count cycles until done (bounded).
   task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, output int lat);
      start         = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      start         = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h0BAD_F00D;
      lat = 0;
      while (!done && lat < BUDGET) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_total++; if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl busy/done=%b required 00", {busy, done}); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b000) $display("FAIL reset_res eq/ne/lt=%b required 000", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_equal;
      int lat;
      run_cmp(32'h1234_5678, 32'h1234_5678, lat);
      n_total++; if (lat !== LAT_FULL) $display("FAIL eq_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b100) $display("FAIL eq_result eq/ne/lt=%b required 100", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL eq_busy_at_done got %b required 0", busy); else n_pass++;
      @(negedge clock);
      n_total++; if (done !== 1'b0) $display("FAIL eq_done_pulse got %b required 0", done); else n_pass++;
   endtask

   task automatic test_less_low_chunk;
      int lat;
      run_cmp(32'h0000_0005, 32'h0000_0007, lat);
      n_total++; if (lat !== LAT_FULL) $display("FAIL lt_low_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b011) $display("FAIL lt_low_result eq/ne/lt=%b required 011", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_signed;
      int lat;
      run_cmp(32'hFFFF_FFFF, 32'h0000_0001, lat);
      n_total++; if (lat !== LAT_TOP) $display("FAIL neg_latency got %0d required %0d", lat, LAT_TOP); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b011) $display("FAIL neg_result eq/ne/lt=%b required 011", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
      run_cmp(32'h7FFF_FFFF, 32'h8000_0000, lat);
      n_total++; if (lat !== LAT_TOP) $display("FAIL maxmin_latency got %0d required %0d", lat, LAT_TOP); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b010) $display("FAIL maxmin_result eq/ne/lt=%b required 010", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
      // Same top nibble sign, ordering decided lower down: 0x8..1 < 0x8..2 as signed.
      run_cmp(32'h8000_0001, 32'h8000_0002, lat);
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b011) $display("FAIL negneg_result eq/ne/lt=%b required 011", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_ignore_start;
      int lat;
      start         = 1'b1;
      data_operandA = 32'd1;
      data_operandB = 32'd2;
      @(negedge clock);
      start = 1'b0;
      lat   = 0;
      repeat (2) begin
         @(negedge clock);
         lat++;
      end
      start         = 1'b1;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      @(negedge clock);
      lat++;
      start = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL ign_busy_held got %b required 1", busy); else n_pass++;
      while (!done && lat < BUDGET) begin
         @(negedge clock);
         lat++;
      end
      n_total++; if (lat !== LAT_FULL) $display("FAIL ign_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b011) $display("FAIL ign_result eq/ne/lt=%b required 011", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
      // Start in the cycle after done must be taken.
      run_cmp(32'd2, 32'd1, lat);
      n_total++; if (lat !== LAT_FULL) $display("FAIL after_done_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b010) $display("FAIL after_done_result eq/ne/lt=%b required 010", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_reset_abort;
      int lat;
      int seen_done;
      start         = 1'b1;
      data_operandA = 32'd0;
      data_operandB = 32'h8000_0000;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b required 0", busy); else n_pass++;
      n_total++; if ({done, isEqual, isNotEqual, isLessThan} !== 4'b0000) $display("FAIL abort_res done/eq/ne/lt=%b required 0000", {done, isEqual, isNotEqual, isLessThan}); else n_pass++;
      reset     = 1'b0;
      seen_done = 0;
      repeat (12) begin
         @(negedge clock);
         if (done) seen_done++;
      end
      n_total++; if (seen_done !== 0) $display("FAIL abort_no_done saw %0d done pulses required 0", seen_done); else n_pass++;
      run_cmp(32'd0, 32'd0, lat);
      n_total++; if (lat !== LAT_FULL) $display("FAIL post_abort_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b100) $display("FAIL post_abort_result eq/ne/lt=%b required 100", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int lat;
      int hold_bad;
      run_cmp(32'd3, 32'd3, lat);
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b100) $display("FAIL b2b_first eq/ne/lt=%b required 100", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
      start         = 1'b1;
      data_operandA = 32'd3;
      data_operandB = 32'd2;
      @(negedge clock);
      start    = 1'b0;
      lat      = 0;
      hold_bad = 0;
      while (!done && lat < BUDGET) begin
         if ({isEqual, isNotEqual, isLessThan} !== 3'b100) hold_bad++;
         @(negedge clock);
         lat++;
      end
      n_total++; if (hold_bad !== 0) $display("FAIL b2b_hold %0d cycles changed, required 0", hold_bad); else n_pass++;
      n_total++; if (lat !== LAT_FULL) $display("FAIL b2b_latency got %0d required %0d", lat, LAT_FULL); else n_pass++;
      n_total++; if ({isEqual, isNotEqual, isLessThan} !== 3'b010) $display("FAIL b2b_second eq/ne/lt=%b required 010", {isEqual, isNotEqual, isLessThan}); else n_pass++;
      @(negedge clock);
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      test_reset();
      test_equal();
      test_less_low_chunk();
      test_signed();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
